ram_sync_param: RTL and testbench

//   Parametrised single-port synchronous RAM. Successor to the fixed 16x8 decoder/tristate RAM.

---
 rtl/ram_sync_param.sv | 100 ++++++++++
 tb/tb_ram_sync_param.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sync_param.sv
// Parametrised single-port synchronous RAM with registered read data,
// read-valid and out-of-range error strobes, and an optional zeroing
// sweep after reset during which requests are ignored.
module ram_sync_param #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 4,
  parameter int DEPTH          = 16,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              err,
  output logic              busy
);

  typedef enum logic {INIT, READY} state_t;

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_EXT   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
  localparam state_t            RESET_STATE = (CLEAR_ON_RESET != 0) ? INIT : READY;

  state_t            state, state_next;
  logic [ADDR_W-1:0] cnt, cnt_next;
  logic              sweep_we;
  logic              accept;
  logic              in_range;

  logic [DATA_W-1:0] mem [DEPTH];

  assign in_range = {1'b0, addr} < DEPTH_EXT;
  assign accept   = req & ~busy;

  // Next-state logic: the sweep walks cnt from 0 to DEPTH-1, then settles in READY.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    busy       = 1'b0;
    sweep_we   = 1'b0;
    case (state)
      INIT: begin
        busy     = 1'b1;
        sweep_we = 1'b1;
        if (cnt == LAST_ADDR) begin
          state_next = READY;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      READY: begin
        state_next = READY;
      end
      default: begin
        state_next = RESET_STATE;
      end
    endcase
  end

  // State register and sweep counter; reset restarts any sweep from word 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RESET_STATE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Storage array is never reset; it is written by the sweep or by in-range writes.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[cnt] <= '0;
    end else if (accept && wr_en && in_range) begin
      mem[addr] <= din;
    end
  end

  // Registered read port and status strobes; out-of-range reads return zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      dout_valid <= accept & ~wr_en;
      err        <= accept & ~in_range;
      if (accept && !wr_en) begin
        dout <= in_range ? mem[addr] : '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_sync_param.sv
// Testbench for ram_sync_param: a 16-word instance and a 12-word instance
// (non-power-of-two depth) checked against array-based reference models.
module tb_ram_sync_param;

  logic       clk = 1'b0;
  logic       rst;

  logic       req, wr_en;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_valid, err, busy;

  logic       req_b, wr_en_b;
  logic [3:0] addr_b;
  logic [7:0] din_b;
  logic [7:0] dout_b;
  logic       dout_valid_b, err_b, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model   [16];
  logic [7:0] model_b [12];
  logic [7:0] exp_dout, exp_dout_b;
  logic       exp_valid, exp_err, exp_valid_b, exp_err_b;

  always #5 clk = ~clk;

  ram_sync_param #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst), .req(req), .wr_en(wr_en), .addr(addr), .din(din),
    .dout(dout), .dout_valid(dout_valid), .err(err), .busy(busy)
  );

  ram_sync_param #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .CLEAR_ON_RESET(1)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .wr_en(wr_en_b), .addr(addr_b), .din(din_b),
    .dout(dout_b), .dout_valid(dout_valid_b), .err(err_b), .busy(busy_b)
  );

  // One clock on the 16-word instance; the model predicts the outputs after the edge.
  task automatic cyc(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d);
    req = r; wr_en = w; addr = a; din = d;
    @(posedge clk); #1;
    req = 1'b0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (r) begin
      if (w) model[a] = d;
      else begin
        exp_dout  = model[a];
        exp_valid = 1'b1;
      end
    end
  endtask

  // One clock on the 12-word instance; addresses 12..15 are out of range.
  task automatic cyc_b(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d);
    req_b = r; wr_en_b = w; addr_b = a; din_b = d;
    @(posedge clk); #1;
    req_b = 1'b0;
    exp_valid_b = 1'b0;
    exp_err_b   = 1'b0;
    if (r) begin
      exp_err_b = (a >= 4'd12);
      if (!w) begin
        exp_valid_b = 1'b1;
        exp_dout_b  = (a < 4'd12) ? model_b[a] : 8'h00;
      end else if (a < 4'd12) begin
        model_b[a] = d;
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    for (int i = 0; i < 12; i++) model_b[i] = 8'h00;
    exp_dout = 8'h00; exp_dout_b = 8'h00;
    exp_valid = 1'b0; exp_valid_b = 1'b0;
    exp_err = 1'b0; exp_err_b = 1'b0;
  endtask

  task automatic test_reset();
    int n, nb;
    rst = 1'b0;
    req = 0; wr_en = 0; addr = 0; din = 0;
    req_b = 0; wr_en_b = 0; addr_b = 0; din_b = 0;
    #12;
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h want 00", dout); end
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", dout_valid); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b want 1", busy); end
    n_checks++; if (busy_b !== 1'b1) begin n_fail++; $display("FAIL reset_busy_b got %b want 1", busy_b); end
    @(posedge clk); #1;
    rst = 1'b1;
    n = 0; nb = 0;
    while ((busy || busy_b) && n < 64) begin
      if (busy) n++;
      if (busy_b) nb++;
      n_checks++;
      if (dout_valid !== 1'b0 || err !== 1'b0) begin
        n_fail++; $display("FAIL init_quiet valid=%b err=%b want 0 0", dout_valid, err);
      end
      @(posedge clk); #1;
    end
    n_checks++; if (n != 16) begin n_fail++; $display("FAIL busy_len got %0d want 16", n); end
    n_checks++; if (nb != 12) begin n_fail++; $display("FAIL busy_len_b got %0d want 12", nb); end
    model_clear();
  endtask

  task automatic test_clear_readback();
    for (int a = 0; a < 16; a++) begin
      cyc(1'b1, 1'b0, 4'(a), 8'h00);
      n_checks++;
      if (dout !== exp_dout || dout_valid !== 1'b1 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_read[%0d] got %h/%b/%b want %h/1/0", a, dout, dout_valid, err, exp_dout);
      end
    end
  endtask

  task automatic test_write_read();
    cyc(1'b1, 1'b1, 4'd3, 8'hA5);
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL wr_valid got %b want 0", dout_valid); end
    cyc(1'b1, 1'b0, 4'd3, 8'h00);
    n_checks++;
    if (dout !== 8'hA5 || dout_valid !== 1'b1) begin
      n_fail++; $display("FAIL raw_read got %h/%b want a5/1", dout, dout_valid);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 4'($urandom_range(0, 15)), 8'($urandom));
      n_checks++;
      if (dout !== 8'hA5 || dout_valid !== 1'b0 || err !== 1'b0) begin
        n_fail++; $display("FAIL idle_hold got %h/%b/%b want a5/0/0", dout, dout_valid, err);
      end
    end
  endtask

  task automatic test_back_to_back();
    cyc(1'b1, 1'b1, 4'd0, 8'h11);
    cyc(1'b1, 1'b1, 4'd15, 8'hFF);
    cyc(1'b1, 1'b0, 4'd15, 8'h00);
    n_checks++;
    if (dout !== 8'hFF || dout_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first got %h/%b want ff/1", dout, dout_valid);
    end
    cyc(1'b1, 1'b0, 4'd0, 8'h00);
    n_checks++;
    if (dout !== 8'h11 || dout_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second got %h/%b want 11/1", dout, dout_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom_range(0, 15)), 8'($urandom));
      n_checks++;
      if (dout !== exp_dout || dout_valid !== exp_valid || err !== exp_err) begin
        n_fail++;
        $display("FAIL random[%0d] got %h/%b/%b want %h/%b/%b", i, dout, dout_valid, err,
                 exp_dout, exp_valid, exp_err);
      end
    end
  endtask

  task automatic test_out_of_range();
    cyc_b(1'b1, 1'b1, 4'd5, 8'h9A);
    cyc_b(1'b1, 1'b0, 4'd5, 8'h00);
    n_checks++;
    if (dout_b !== 8'h9A || dout_valid_b !== 1'b1 || err_b !== 1'b0) begin
      n_fail++; $display("FAIL oor_setup got %h/%b/%b want 9a/1/0", dout_b, dout_valid_b, err_b);
    end
    cyc_b(1'b1, 1'b1, 4'd13, 8'h77);
    n_checks++;
    if (err_b !== 1'b1 || dout_valid_b !== 1'b0 || dout_b !== 8'h9A) begin
      n_fail++; $display("FAIL oor_write got err=%b valid=%b dout=%h want 1/0/9a", err_b, dout_valid_b, dout_b);
    end
    cyc_b(1'b1, 1'b0, 4'd13, 8'h00);
    n_checks++;
    if (err_b !== 1'b1 || dout_valid_b !== 1'b1 || dout_b !== 8'h00) begin
      n_fail++; $display("FAIL oor_read got err=%b valid=%b dout=%h want 1/1/00", err_b, dout_valid_b, dout_b);
    end
    cyc_b(1'b0, 1'b0, 4'd0, 8'h00);
    n_checks++;
    if (err_b !== 1'b0 || dout_valid_b !== 1'b0) begin
      n_fail++; $display("FAIL oor_idle got err=%b valid=%b want 0/0", err_b, dout_valid_b);
    end
    for (int i = 0; i < 200; i++) begin
      cyc_b(($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom_range(0, 15)), 8'($urandom));
      n_checks++;
      if (dout_b !== exp_dout_b || dout_valid_b !== exp_valid_b || err_b !== exp_err_b) begin
        n_fail++;
        $display("FAIL oor_random[%0d] got %h/%b/%b want %h/%b/%b", i, dout_b, dout_valid_b, err_b,
                 exp_dout_b, exp_valid_b, exp_err_b);
      end
    end
    for (int a = 0; a < 12; a++) begin
      cyc_b(1'b1, 1'b0, 4'(a), 8'h00);
      n_checks++;
      if (dout_b !== model_b[a] || dout_valid_b !== 1'b1 || err_b !== 1'b0) begin
        n_fail++; $display("FAIL oor_sweep[%0d] got %h/%b/%b want %h/1/0", a, dout_b, dout_valid_b, err_b, model_b[a]);
      end
    end
  endtask

  task automatic test_reset_mid_and_busy();
    int n;
    cyc(1'b1, 1'b1, 4'd1, 8'h3C);
    cyc(1'b1, 1'b0, 4'd1, 8'h00);
    n_checks++;
    if (dout !== 8'h3C || dout_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_setup got %h/%b want 3c/1", dout, dout_valid);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (dout !== 8'h00 || dout_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL async_ready got %h/%b/%b want 00/0/1", dout, dout_valid, busy);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if (dout !== 8'h00 || dout_valid !== 1'b0 || err !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL async_init got %h/%b/%b/%b want 00/0/0/1", dout, dout_valid, err, busy);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    n = 0;
    while (busy && n < 64) begin
      n++;
      n_checks++;
      if (dout_valid !== 1'b0 || err !== 1'b0) begin
        n_fail++; $display("FAIL busy_ignore valid=%b err=%b want 0/0", dout_valid, err);
      end
      if (n >= 8) begin
        req = 1'b1; wr_en = 1'b1; addr = 4'd2; din = 8'h55;
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
    n_checks++; if (n != 16) begin n_fail++; $display("FAIL restart_len got %0d want 16", n); end
    model_clear();
    cyc(1'b1, 1'b0, 4'd1, 8'h00);
    n_checks++;
    if (dout !== 8'h00 || dout_valid !== 1'b1) begin
      n_fail++; $display("FAIL restart_read1 got %h/%b want 00/1", dout, dout_valid);
    end
    cyc(1'b1, 1'b0, 4'd2, 8'h00);
    n_checks++;
    if (dout !== 8'h00 || dout_valid !== 1'b1) begin
      n_fail++; $display("FAIL busy_write_dropped got %h/%b want 00/1", dout, dout_valid);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clear_readback();
    test_write_read();
    test_back_to_back();
    test_random();
    test_out_of_range();
    test_reset_mid_and_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
